// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing helpers.
// The helpers are also used by the companion transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int unsigned clocks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // Bits needed to hold values 0..max_val; never less than one.
  function automatic int unsigned counter_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so that the line reads as idle out of reset.
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing with configurable payload width.
// The start bit is verified at its centre, and then every bit is sampled one bit period apart.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_busy
);

  localparam int unsigned CPB      = clocks_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned HALF_BIT = CPB / 2;
  localparam int unsigned CNT_W    = counter_width(CPB - 1);
  localparam int unsigned BIT_W    = counter_width(PAYLOAD_BITS - 1);

  logic rxd_s;
  logic rxd_prev_q;

  uart_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d;

  uart_sync2 u_sync (
    .clk_i (CLK),
    .rst_i (reset),
    .d_i   (uart_rxd),
    .q_o   (rxd_s)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      rxd_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      rxd_prev_q <= rxd_s;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        // A line parked low (break) never produces a new edge here.
        if (uart_rx_en && rxd_prev_q && !rxd_s) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
          cnt_d   = '0;
          state_d = rxd_s ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d = '0;
          // LSB arrives first, so shift in from the top.
          shreg_d = {rxd_s, shreg_q[PAYLOAD_BITS-1:1]};
          if (bit_q == BIT_W'(PAYLOAD_BITS - 1)) begin
            bit_d   = '0;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      ST_STOP: begin
        // Leaving at the stop-bit centre leaves half a bit to catch the next start edge.
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rxd_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign uart_rx_data      = data_q;
  assign uart_rx_valid     = valid_q;
  assign uart_rx_frame_err = ferr_q;
  assign uart_rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 10 clocks per bit; the reference model
// tracks frames at the byte level: good stop bit -> new data, bad -> frame error.
module tb_uart_rx;

  localparam int CLK_HZ   = 1000000;
  localparam int BIT_RATE = 100000;
  localparam int PB       = 8;
  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int HALF     = CPB / 2;

  logic          CLK        = 1'b0;
  logic          reset      = 1'b1;
  logic          uart_rxd   = 1'b1;
  logic          uart_rx_en = 1'b0;
  logic [PB-1:0] uart_rx_data;
  logic          uart_rx_valid;
  logic          uart_rx_frame_err;
  logic          uart_rx_busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] got_q[$];
  int         ferr_cnt  = 0;
  int         both_cnt  = 0;
  bit         busy_seen = 1'b0;
  logic [7:0] exp_data  = 8'h00;

  uart_rx #(
    .CLK_HZ       (CLK_HZ),
    .BIT_RATE     (BIT_RATE),
    .PAYLOAD_BITS (PB)
  ) dut (
    .CLK               (CLK),
    .reset             (reset),
    .uart_rxd          (uart_rxd),
    .uart_rx_en        (uart_rx_en),
    .uart_rx_data      (uart_rx_data),
    .uart_rx_valid     (uart_rx_valid),
    .uart_rx_frame_err (uart_rx_frame_err),
    .uart_rx_busy      (uart_rx_busy)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (uart_rx_valid === 1'b1) got_q.push_back(uart_rx_data);
    if (uart_rx_frame_err === 1'b1) ferr_cnt++;
    if (uart_rx_valid === 1'b1 && uart_rx_frame_err === 1'b1) both_cnt++;
    if (uart_rx_busy === 1'b1) busy_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    got_q.delete();
    ferr_cnt  = 0;
    busy_seen = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int gap_bits);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < PB; i++) begin
      uart_rxd = d[i];
      repeat (CPB) @(negedge CLK);
    end
    uart_rxd = stop_ok;
    repeat (CPB) @(negedge CLK);
    uart_rxd = 1'b1;
    repeat (gap_bits * CPB) @(negedge CLK);
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    uart_rxd = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (uart_rx_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h expected 00", uart_rx_data);
    end
    checks++;
    if (uart_rx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", uart_rx_valid);
    end
    checks++;
    if (uart_rx_frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_ferr: got %b expected 0", uart_rx_frame_err);
    end
    checks++;
    if (uart_rx_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", uart_rx_busy);
    end
    reset      = 1'b0;
    exp_data   = 8'h00;
    uart_rx_en = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_single();
    clear_obs();
    send_frame(8'hA5, 1'b1, 1);
    exp_data = 8'hA5;
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d pulses expected 1", got_q.size());
    end
    checks++;
    if ((got_q.size() > 0 ? got_q[0] : 8'hxx) !== 8'hA5) begin
      errors++; $display("FAIL single_data: got %h expected a5", uart_rx_data);
    end
    checks++;
    if (ferr_cnt != 0) begin
      errors++; $display("FAIL single_ferr: got %0d expected 0", ferr_cnt);
    end
    checks++;
    if (busy_seen !== 1'b1) begin
      errors++; $display("FAIL single_busy_seen: got %b expected 1", busy_seen);
    end
    checks++;
    if (uart_rx_busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_end: got %b expected 0", uart_rx_busy);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_frame(8'h3C, 1'b1, 0);
    send_frame(8'hC3, 1'b1, 1);
    exp_data = 8'hC3;
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d pulses expected 2", got_q.size());
    end
    checks++;
    if ((got_q.size() > 0 ? got_q[0] : 8'hxx) !== 8'h3C) begin
      errors++; $display("FAIL b2b_first: got %h expected 3c", (got_q.size() > 0 ? got_q[0] : 8'hxx));
    end
    checks++;
    if ((got_q.size() > 1 ? got_q[1] : 8'hxx) !== 8'hC3) begin
      errors++; $display("FAIL b2b_second: got %h expected c3", (got_q.size() > 1 ? got_q[1] : 8'hxx));
    end
  endtask

  task automatic test_frame_err();
    clear_obs();
    send_frame(8'h55, 1'b0, 1);
    checks++;
    if (ferr_cnt != 1) begin
      errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt);
    end
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL ferr_valid: got %0d valid pulses expected 0", got_q.size());
    end
    checks++;
    if (uart_rx_data !== exp_data) begin
      errors++; $display("FAIL ferr_hold: got %h expected %h", uart_rx_data, exp_data);
    end
  endtask

  task automatic test_glitch();
    int n;
    clear_obs();
    uart_rxd = 1'b0;
    repeat (3) @(negedge CLK);
    uart_rxd = 1'b1;
    n = 0;
    while (uart_rx_busy !== 1'b0 && n < HALF + 3) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (uart_rx_busy !== 1'b0) begin
      errors++; $display("FAIL glitch_busy: got %b after %0d cycles expected 0", uart_rx_busy, n);
    end
    checks++;
    if (busy_seen !== 1'b1) begin
      errors++; $display("FAIL glitch_start: got busy_seen=%b expected 1", busy_seen);
    end
    repeat (2 * CPB) @(negedge CLK);
    checks++;
    if (got_q.size() != 0 || ferr_cnt != 0) begin
      errors++; $display("FAIL glitch_pulse: got valid=%0d ferr=%0d expected 0/0", got_q.size(), ferr_cnt);
    end
  endtask

  task automatic test_break();
    clear_obs();
    uart_rxd = 1'b0;
    repeat (3 * (PB + 2) * CPB) @(negedge CLK);
    checks++;
    if (ferr_cnt != 1) begin
      errors++; $display("FAIL break_ferr: got %0d expected 1", ferr_cnt);
    end
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL break_valid: got %0d expected 0", got_q.size());
    end
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(negedge CLK);
    clear_obs();
    send_frame(8'h96, 1'b1, 1);
    exp_data = 8'h96;
    checks++;
    if (got_q.size() != 1 || ferr_cnt != 0) begin
      errors++; $display("FAIL break_recover: got valid=%0d ferr=%0d expected 1/0", got_q.size(), ferr_cnt);
    end
    checks++;
    if (uart_rx_data !== exp_data) begin
      errors++; $display("FAIL break_data: got %h expected %h", uart_rx_data, exp_data);
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge CLK);
    uart_rxd = 1'b1;
    repeat (4 * CPB + HALF) @(negedge CLK);
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    exp_data = 8'h00;
    checks++;
    if (uart_rx_busy !== 1'b0 || uart_rx_data !== exp_data) begin
      errors++; $display("FAIL rstmid_state: got busy=%b data=%h expected 0/%h", uart_rx_busy, uart_rx_data, exp_data);
    end
    reset = 1'b0;
    repeat (3 * CPB) @(negedge CLK);
    checks++;
    if (got_q.size() != 0 || ferr_cnt != 0) begin
      errors++; $display("FAIL rstmid_pulse: got valid=%0d ferr=%0d expected 0/0", got_q.size(), ferr_cnt);
    end
    clear_obs();
    send_frame(8'h12, 1'b1, 1);
    exp_data = 8'h12;
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL rstmid_count: got %0d expected 1", got_q.size());
    end
    checks++;
    if (uart_rx_data !== exp_data) begin
      errors++; $display("FAIL rstmid_data: got %h expected %h", uart_rx_data, exp_data);
    end
  endtask

  task automatic test_enable();
    uart_rx_en = 1'b0;
    repeat (2) @(negedge CLK);
    clear_obs();
    send_frame(8'h77, 1'b1, 1);
    checks++;
    if (got_q.size() != 0 || ferr_cnt != 0) begin
      errors++; $display("FAIL en_off_pulse: got valid=%0d ferr=%0d expected 0/0", got_q.size(), ferr_cnt);
    end
    checks++;
    if (busy_seen !== 1'b0) begin
      errors++; $display("FAIL en_off_busy: got busy_seen=%b expected 0", busy_seen);
    end
    uart_rx_en = 1'b1;
    repeat (2) @(negedge CLK);
    clear_obs();
    send_frame(8'h77, 1'b1, 1);
    exp_data = 8'h77;
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL en_on_count: got %0d expected 1", got_q.size());
    end
    checks++;
    if (uart_rx_data !== exp_data) begin
      errors++; $display("FAIL en_on_data: got %h expected %h", uart_rx_data, exp_data);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int         exp_ferr;
    logic [7:0] d;
    bit         ok;
    int         gap;
    exp_ferr = 0;
    clear_obs();
    for (int f = 0; f < 20; f++) begin
      d   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 3) != 0);
      // A bad stop bit needs an idle bit after it, or the next start has no falling edge.
      gap = ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(d, ok, gap);
      if (ok) begin
        exp_q.push_back(d);
        exp_data = d;
      end else begin
        exp_ferr++;
      end
    end
    repeat (2 * CPB) @(negedge CLK);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((i < got_q.size() ? got_q[i] : 8'hxx) !== exp_q[i]) begin
        errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, (i < got_q.size() ? got_q[i] : 8'hxx), exp_q[i]);
      end
    end
    checks++;
    if (ferr_cnt != exp_ferr) begin
      errors++; $display("FAIL rand_ferr: got %0d expected %0d", ferr_cnt, exp_ferr);
    end
    checks++;
    if (uart_rx_data !== exp_data) begin
      errors++; $display("FAIL rand_final_data: got %h expected %h", uart_rx_data, exp_data);
    end
    checks++;
    if (both_cnt != 0) begin
      errors++; $display("FAIL valid_and_ferr: got %0d overlapping cycles expected 0", both_cnt);
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_break();
    test_reset_mid();
    test_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 50000000, clock frequency in Hz.
REQ-002 Parameter BIT_RATE, default 9600, serial bit rate in bits/s.
REQ-003 Parameter PAYLOAD_BITS, default 8, data bits per frame (range 5..9).
REQ-004 CLK  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 uart_rxd  input  1  asynchronous serial line; idles high.
REQ-007 uart_rx_en  input  1  receive enable; when low, the block stays in IDLE and ignores the line.
REQ-008 uart_rx_data  output  PAYLOAD_BITS  last correctly received payload, LSB first on the line.
REQ-009 uart_rx_valid  output  1  one-cycle pulse: uart_rx_data updated with a good frame.
REQ-010 uart_rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 uart_rx_busy  output  1  high in every state except IDLE.

Function
REQ-012 Frame SHALL be 1 start bit (0), PAYLOAD_BITS data bits LSB first, 1 stop bit (1); no parity.
REQ-013 CLOCKS_PER_BIT SHALL equal CLK_HZ/BIT_RATE (integer division); HALF_BIT SHALL equal CLOCKS_PER_BIT/2.
REQ-014 uart_rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value, adding 2 cycles of latency.
REQ-015 The bit-period counter SHALL be wide enough for CLOCKS_PER_BIT-1 and SHALL reload to 0 on every state change.
REQ-016 States: IDLE, START, DATA, STOP.
REQ-017 IDLE->START on a synchronized falling edge (previous 1, current 0) while uart_rx_en=1.
REQ-018 START: at counter=HALF_BIT-1, a synchronized line of 0 SHALL go to DATA; a line of 1 is a glitch and SHALL return to IDLE with no output pulse.
REQ-019 DATA: sample every CLOCKS_PER_BIT cycles (bit centre); shift into the payload register LSB first; after PAYLOAD_BITS samples go to STOP.
REQ-020 STOP: sample at the bit centre; a sample of 1 SHALL load uart_rx_data and pulse uart_rx_valid on the next cycle; a sample of 0 SHALL pulse uart_rx_frame_err and leave uart_rx_data unchanged; in both cases go to IDLE at the same edge.
REQ-021 Returning to IDLE at stop-bit centre SHALL permit back-to-back frames with no idle gap.
REQ-022 A line held low (break) SHALL yield one frame error, then no new frame until a fresh falling edge.
REQ-023 uart_rx_valid and uart_rx_frame_err SHALL never be high in the same cycle.
REQ-024 Deasserting uart_rx_en mid-frame SHALL NOT abort the frame; it takes effect only in IDLE.

Reset
REQ-025 reset=1 at a rising edge SHALL force IDLE, counters to 0, synchronizer flops to 1, uart_rx_data to 0, and uart_rx_valid, uart_rx_frame_err and uart_rx_busy to 0.
REQ-026 Reset mid-frame SHALL discard the partial frame with no pulse; reception restarts only on the next falling edge after reset is released.

Structure
REQ-027 Package uart_pkg SHALL hold the state encoding and a function computing clocks-per-bit from CLK_HZ/BIT_RATE, shared with uart_tx.
REQ-028 One sub-module, uart_sync2 (2-flop synchronizer, reset value 1), SHALL be instantiated; everything else is flat in uart_rx.

Verification (CLK_HZ=1000000, BIT_RATE=100000, so 10 clocks/bit)
REQ-029 Send 0xA5 as a clean frame -> exactly one uart_rx_valid pulse with uart_rx_data=0xA5; uart_rx_frame_err stays 0.
REQ-030 Send 0x3C then 0xC3 back-to-back with no idle gap -> two valid pulses, data 0x3C then 0xC3.
REQ-031 Send 0x55 with the stop bit driven 0 -> one uart_rx_frame_err pulse, no valid pulse, uart_rx_data holds its previous value.
REQ-032 Pulse uart_rxd low for 3 clocks -> no output pulse, busy returns to 0 within HALF_BIT+3 cycles.
REQ-033 Assert reset during data bit 4 of 0xFF, release it, then send 0x12 -> no pulse for the aborted frame; one valid pulse with uart_rx_data=0x12.
REQ-034 Hold uart_rx_en=0 and send 0x77 -> no pulse, busy stays 0; set uart_rx_en=1 and send 0x77 -> one valid pulse with uart_rx_data=0x77.
